// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the RV32I memory stage: access encodings,
// FSM states, byte-enable constants and small decode helpers.
package mem_access_stage_pkg;

   typedef enum logic [2:0] {
      F3_B  = 3'b000,
      F3_H  = 3'b001,
      F3_W  = 3'b010,
      F3_BU = 3'b100,
      F3_HU = 3'b101
   } funct3_e;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_t;

   localparam logic [3:0] BE_B0  = 4'b0001;
   localparam logic [3:0] BE_LO  = 4'b0011;
   localparam logic [3:0] BE_HI  = 4'b1100;
   localparam logic [3:0] BE_ALL = 4'b1111;

   // Misaligned or unsupported size/sign combination.
   function automatic logic mem_fault(
      input logic [2:0] f3,
      input logic [1:0] a,
      input logic       st
   );
      logic bad;
      bad = 1'b1;
      case (f3)
         F3_B:    bad = 1'b0;
         F3_H:    bad = a[0];
         F3_W:    bad = |a;
         F3_BU:   bad = st;
         F3_HU:   bad = st | a[0];
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic logic [3:0] be_mask(
      input logic [1:0] sz,
      input logic [1:0] a
   );
      logic [3:0] be;
      case (sz)
         2'b00:   be = BE_B0 << a;
         2'b01:   be = a[1] ? BE_HI : BE_LO;
         default: be = BE_ALL;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load lane extraction with sign/zero extension for LB/LH/LW/LBU/LHU.
module load_align
   import mem_access_stage_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = rdata[7:0];
      case (addr_lo)
         2'd0:    byte_v = rdata[7:0];
         2'd1:    byte_v = rdata[15:8];
         2'd2:    byte_v = rdata[23:16];
         default: byte_v = rdata[31:24];
      endcase
      half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      data = rdata;
      case (funct3)
         F3_B:    data = {{24{byte_v[7]}}, byte_v};
         F3_H:    data = {{16{half_v[15]}}, half_v};
         F3_BU:   data = {24'h0, byte_v};
         F3_HU:   data = {16'h0, half_v};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// RV32I MEM stage: data-memory req/ack handshake, store lane steering,
// load alignment and the MEM/WB pipeline register.
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
)
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      ValidM,
   input  logic [ADDR_WIDTH-1:0]     ALUResultM,
   input  logic [DATA_WIDTH-1:0]     WriteDataM,
   input  logic                      MemReadM,
   input  logic                      MemWriteM,
   input  logic [2:0]                Funct3M,
   input  logic                      RegWriteM,
   input  logic [1:0]                ResultSrcM,
   input  logic [REG_ADDR_WIDTH-1:0] RdM,
   output logic                      StallM,
   output logic                      dmem_req,
   output logic                      dmem_we,
   output logic [ADDR_WIDTH-1:0]     dmem_addr,
   output logic [DATA_WIDTH-1:0]     dmem_wdata,
   output logic [3:0]                dmem_be,
   input  logic                      dmem_ack,
   input  logic [DATA_WIDTH-1:0]     dmem_rdata,
   output logic [ADDR_WIDTH-1:0]     ALUResultW,
   output logic [DATA_WIDTH-1:0]     ReadDataW,
   output logic [1:0]                ResultSrcW,
   output logic [REG_ADDR_WIDTH-1:0] RdW,
   output logic                      RegWriteW,
   output logic                      FaultW
);

   mem_state_t state_q, state_d;

   logic [ADDR_WIDTH-1:0]     haddr_q, haddr_d;
   logic [DATA_WIDTH-1:0]     hwdata_q, hwdata_d;
   logic [3:0]                hbe_q, hbe_d;
   logic                      hwe_q, hwe_d;
   logic [2:0]                hf3_q, hf3_d;

   logic [ADDR_WIDTH-1:0]     alu_w_q, alu_w_d;
   logic [DATA_WIDTH-1:0]     rd_w_q, rd_w_d;
   logic [1:0]                src_w_q, src_w_d;
   logic [REG_ADDR_WIDTH-1:0] rdi_w_q, rdi_w_d;
   logic                      rw_w_q, rw_w_d;
   logic                      flt_w_q, flt_w_d;

   logic                      mem_op;
   logic                      fault;
   logic                      access;
   logic                      req_int;
   logic                      is_load;
   logic [3:0]                be_m;
   logic [DATA_WIDTH-1:0]     wdata_m;
   logic [1:0]                ld_lo;
   logic [2:0]                ld_f3;
   logic [31:0]               ld_data;

   assign mem_op = ValidM & (MemReadM | MemWriteM);
   assign fault  = mem_op & mem_fault(Funct3M, ALUResultM[1:0], MemWriteM);
   assign access = mem_op & ~fault;
   assign be_m   = be_mask(Funct3M[1:0], ALUResultM[1:0]);

   always_comb begin
      case (Funct3M[1:0])
         2'b00:   wdata_m = {4{WriteDataM[7:0]}};
         2'b01:   wdata_m = {2{WriteDataM[15:0]}};
         default: wdata_m = WriteDataM;
      endcase
   end

   // IDLE drives the port straight from M; WAIT replays the held request.
   always_comb begin
      state_d    = state_q;
      req_int    = 1'b0;
      dmem_we    = MemWriteM;
      dmem_addr  = {ALUResultM[ADDR_WIDTH-1:2], 2'b00};
      dmem_wdata = wdata_m;
      dmem_be    = be_m;
      is_load    = access & ~MemWriteM;
      ld_lo      = ALUResultM[1:0];
      ld_f3      = Funct3M;
      haddr_d    = haddr_q;
      hwdata_d   = hwdata_q;
      hbe_d      = hbe_q;
      hwe_d      = hwe_q;
      hf3_d      = hf3_q;
      unique case (state_q)
         IDLE: begin
            req_int = access;
            if (access && !dmem_ack) begin
               state_d  = WAIT;
               haddr_d  = ALUResultM;
               hwdata_d = wdata_m;
               hbe_d    = be_m;
               hwe_d    = MemWriteM;
               hf3_d    = Funct3M;
            end
         end
         WAIT: begin
            req_int    = 1'b1;
            dmem_we    = hwe_q;
            dmem_addr  = {haddr_q[ADDR_WIDTH-1:2], 2'b00};
            dmem_wdata = hwdata_q;
            dmem_be    = hbe_q;
            is_load    = ~hwe_q;
            ld_lo      = haddr_q[1:0];
            ld_f3      = hf3_q;
            if (dmem_ack)
               state_d = IDLE;
         end
      endcase
   end

   assign dmem_req = req_int & rst_n;
   assign StallM   = dmem_req & ~dmem_ack;

   load_align u_load_align (
      .rdata   (dmem_rdata),
      .addr_lo (ld_lo),
      .funct3  (ld_f3),
      .data    (ld_data)
   );

   // A stalled cycle inserts a bubble into WB but keeps the data fields.
   always_comb begin
      alu_w_d = alu_w_q;
      rd_w_d  = rd_w_q;
      src_w_d = src_w_q;
      rdi_w_d = rdi_w_q;
      rw_w_d  = 1'b0;
      flt_w_d = 1'b0;
      if (!StallM) begin
         alu_w_d = ALUResultM;
         rd_w_d  = is_load ? ld_data : '0;
         src_w_d = ResultSrcM;
         rdi_w_d = RdM;
         rw_w_d  = ValidM & RegWriteM & ~fault;
         flt_w_d = fault & (state_q == IDLE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         haddr_q  <= '0;
         hwdata_q <= '0;
         hbe_q    <= '0;
         hwe_q    <= 1'b0;
         hf3_q    <= '0;
         alu_w_q  <= '0;
         rd_w_q   <= '0;
         src_w_q  <= '0;
         rdi_w_q  <= '0;
         rw_w_q   <= 1'b0;
         flt_w_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         haddr_q  <= haddr_d;
         hwdata_q <= hwdata_d;
         hbe_q    <= hbe_d;
         hwe_q    <= hwe_d;
         hf3_q    <= hf3_d;
         alu_w_q  <= alu_w_d;
         rd_w_q   <= rd_w_d;
         src_w_q  <= src_w_d;
         rdi_w_q  <= rdi_w_d;
         rw_w_q   <= rw_w_d;
         flt_w_q  <= flt_w_d;
      end
   end

   assign ALUResultW = alu_w_q;
   assign ReadDataW  = rd_w_q;
   assign ResultSrcW = src_w_q;
   assign RdW        = rdi_w_q;
   assign RegWriteW  = rw_w_q;
   assign FaultW     = flt_w_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed spec cases plus
// randomized accesses against an arithmetic reference model.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ValidM, MemReadM, MemWriteM, RegWriteM;
   logic [31:0] ALUResultM, WriteDataM;
   logic [2:0]  Funct3M;
   logic [1:0]  ResultSrcM;
   logic [4:0]  RdM;
   logic        StallM, dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic [31:0] ALUResultW, ReadDataW;
   logic [1:0]  ResultSrcW;
   logic [4:0]  RdW;
   logic        RegWriteW, FaultW;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mem_access_stage dut (
      .clk(clk), .rst_n(rst_n), .ValidM(ValidM),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
      .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .RdM(RdM),
      .StallM(StallM), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
      .ResultSrcW(ResultSrcW), .RdW(RdW), .RegWriteW(RegWriteW),
      .FaultW(FaultW)
   );

   // ---------------- reference model ----------------
   function automatic bit m_fault(input int f3, input int unsigned a, input bit wr);
      int sz;
      sz = f3 % 4;
      if (f3 == 3 || f3 == 6 || f3 == 7) return 1;
      if (wr && f3 >= 4) return 1;
      if (sz == 1 && (a % 2) != 0) return 1;
      if (sz == 2 && (a % 4) != 0) return 1;
      return 0;
   endfunction

   function automatic logic [3:0] m_be(input int f3, input int unsigned a);
      int sz;
      sz = f3 % 4;
      if (sz == 0) return 4'(1 << (a % 4));
      if (sz == 1) return 4'(3 << (a % 4));
      return 4'd15;
   endfunction

   function automatic logic [31:0] m_wdata(input int f3, input logic [31:0] d);
      int sz;
      sz = f3 % 4;
      if (sz == 0) return (d % 256) * 32'h0101_0101;
      if (sz == 1) return (d % 65536) * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] m_load(input int f3, input int unsigned a,
                                          input logic [31:0] rd);
      logic [31:0] v;
      logic [31:0] b;
      logic [31:0] h;
      v = rd >> ((a % 4) * 8);
      b = v % 256;
      h = v % 65536;
      case (f3)
         0: return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
         1: return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
         4: return b;
         5: return h;
         default: return rd;
      endcase
   endfunction

   task automatic drive_m(input logic v, rd, wr, input logic [2:0] f3,
                          input logic [31:0] a, wd, input logic rw,
                          input logic [1:0] rs, input logic [4:0] rdi);
      ValidM = v; MemReadM = rd; MemWriteM = wr; Funct3M = f3;
      ALUResultM = a; WriteDataM = wd; RegWriteM = rw;
      ResultSrcM = rs; RdM = rdi;
   endtask

   // One instruction, entered and left at a negedge.
   task automatic run_op(input string nm, input logic v, rd, wr,
                         input logic [2:0] f3, input logic [31:0] a, wd, rdat,
                         input int waits, input logic rw,
                         input logic [1:0] rs, input logic [4:0] rdi);
      bit flt, acc, ld;
      int n;
      logic [31:0] erd;
      flt = v && (rd || wr) && m_fault(int'(f3), a, wr);
      acc = v && (rd || wr) && !flt;
      ld  = acc && !wr;
      erd = ld ? m_load(int'(f3), a, rdat) : 32'h0;
      n   = acc ? waits : 0;
      drive_m(v, rd, wr, f3, a, wd, rw, rs, rdi);
      for (int c = 0; c <= n; c++) begin
         dmem_ack   = acc ? (c == n) : 1'($urandom % 2);
         dmem_rdata = rdat;
         #1;
         tests++;
         if (dmem_req !== acc) begin
            fails++;
            $display("FAIL %s req: got %b want %b", nm, dmem_req, acc);
         end
         tests++;
         if (StallM !== (acc && c < n)) begin
            fails++;
            $display("FAIL %s stall c%0d: got %b want %b", nm, c, StallM, acc && c < n);
         end
         if (acc) begin
            tests++;
            if ({dmem_we, dmem_addr, dmem_be} !== {wr, a & 32'hFFFF_FFFC, m_be(int'(f3), a)}) begin
               fails++;
               $display("FAIL %s port: got we=%b addr=%h be=%b want we=%b addr=%h be=%b",
                        nm, dmem_we, dmem_addr, dmem_be, wr, a & 32'hFFFF_FFFC,
                        m_be(int'(f3), a));
            end
            if (wr) begin
               tests++;
               if (dmem_wdata !== m_wdata(int'(f3), wd)) begin
                  fails++;
                  $display("FAIL %s wdata: got %h want %h", nm, dmem_wdata,
                           m_wdata(int'(f3), wd));
               end
            end
         end
         @(posedge clk);
         #1;
         tests++;
         if (c < n) begin
            if ({RegWriteW, FaultW} !== 2'b00) begin
               fails++;
               $display("FAIL %s bubble c%0d: got rw=%b flt=%b want 0 0", nm, c, RegWriteW, FaultW);
            end
         end else if ({ALUResultW, ReadDataW, ResultSrcW, RdW, RegWriteW, FaultW} !==
                      {a, erd, rs, rdi, v && rw && !flt, flt}) begin
            fails++;
            $display("FAIL %s wb: got alu=%h rd=%h src=%0d rd=%0d rw=%b flt=%b want alu=%h rd=%h src=%0d rd=%0d rw=%b flt=%b",
                     nm, ALUResultW, ReadDataW, ResultSrcW, RdW, RegWriteW, FaultW,
                     a, erd, rs, rdi, v && rw && !flt, flt);
         end
         @(negedge clk);
      end
      dmem_ack = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      drive_m(0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 2'd0, 5'd0);
      dmem_ack = 0; dmem_rdata = 0; rst_n = 0;
      repeat (2) @(negedge clk);
      #1;
      tests++;
      if ({StallM, dmem_req, ALUResultW, ReadDataW, ResultSrcW, RdW, RegWriteW, FaultW} !== '0) begin
         fails++;
         $display("FAIL reset: got req=%b stall=%b alu=%h rd=%h rw=%b flt=%b want all 0",
                  dmem_req, StallM, ALUResultW, ReadDataW, RegWriteW, FaultW);
      end
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      run_op("sw_0wait", 1, 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 2'd0, 5'd0);
      run_op("lb_3wait", 1, 1, 0, 3'b000, 32'h103, 32'hDEADBEEF, 32'h80123456, 3, 1, 2'd1, 5'd7);
      run_op("lhu", 1, 1, 0, 3'b101, 32'h102, 32'h0, 32'hBEEF1234, 1, 1, 2'd1, 5'd8);
      run_op("sh", 1, 0, 1, 3'b001, 32'h102, 32'h5678, 32'h0, 0, 0, 2'd0, 5'd0);
      run_op("lw_fault", 1, 1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 1, 2'd1, 5'd9);
      run_op("alu_op", 1, 0, 0, 3'b000, 32'h1234, 32'h0, 32'h0, 0, 1, 2'd0, 5'd3);
      run_op("bubble", 0, 1, 0, 3'b010, 32'h200, 32'h0, 32'h0, 0, 1, 2'd1, 5'd4);
      run_op("sb_lane2", 1, 0, 1, 3'b000, 32'h2A6, 32'h000000C3, 32'h0, 2, 0, 2'd0, 5'd0);
      run_op("sbu_fault", 1, 0, 1, 3'b100, 32'h300, 32'h1, 32'h0, 0, 0, 2'd0, 5'd0);
      run_op("lh_neg", 1, 1, 0, 3'b001, 32'h402, 32'h0, 32'h8001_7FFF, 0, 1, 2'd1, 5'd5);
   endtask

   task automatic test_wait_hold();
      drive_m(1, 0, 1, 3'b010, 32'h200, 32'h11223344, 0, 2'd0, 5'd0);
      dmem_ack = 0;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) begin
            ALUResultM = $urandom;
            WriteDataM = $urandom;
            Funct3M    = 3'($urandom);
         end
         #1;
         tests++;
         if ({dmem_req, StallM, dmem_we, dmem_addr, dmem_be, dmem_wdata} !==
             {3'b111, 32'h200, 4'hF, 32'h11223344}) begin
            fails++;
            $display("FAIL hold c%0d: got req=%b addr=%h be=%b wdata=%h want 1 200 1111 11223344",
                     c, dmem_req, dmem_addr, dmem_be, dmem_wdata);
         end
         @(negedge clk);
      end
      drive_m(1, 0, 1, 3'b010, 32'h200, 32'h11223344, 0, 2'd0, 5'd0);
      dmem_ack = 1;
      #1;
      tests++;
      if (StallM !== 1'b0) begin
         fails++;
         $display("FAIL hold_ack stall: got %b want 0", StallM);
      end
      @(posedge clk);
      #1;
      tests++;
      if ({ALUResultW, ReadDataW, RegWriteW, FaultW} !== {32'h200, 32'h0, 2'b00}) begin
         fails++;
         $display("FAIL hold_wb: got alu=%h rd=%h rw=%b flt=%b want 200 0 0 0",
                  ALUResultW, ReadDataW, RegWriteW, FaultW);
      end
      @(negedge clk);
      dmem_ack = 0;
   endtask

   task automatic test_reset_mid_wait();
      logic [31:0] r;
      drive_m(1, 1, 0, 3'b010, 32'h300, 32'h0, 1, 2'd1, 5'd6);
      dmem_ack = 0;
      repeat (2) @(negedge clk);
      #2;
      rst_n = 0;
      #1;
      tests++;
      if ({dmem_req, StallM, ALUResultW, ReadDataW, ResultSrcW, RdW, RegWriteW, FaultW} !== '0) begin
         fails++;
         $display("FAIL rst_wait: got req=%b stall=%b alu=%h rw=%b want all 0",
                  dmem_req, StallM, ALUResultW, RegWriteW);
      end
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      r = $urandom;
      run_op("lw_after_rst", 1, 1, 0, 3'b010, 32'h300, 32'h0, r, 1, 1, 2'd1, 5'd6);
   endtask

   task automatic test_random();
      logic [31:0] a, wd, rd;
      logic v, lr, sw, rw;
      int kind;
      for (int i = 0; i < 80; i++) begin
         a    = {20'h0, 12'($urandom)};
         wd   = $urandom;
         rd   = $urandom;
         v    = ($urandom % 8) != 0;
         kind = $urandom % 5;
         lr   = (kind == 0 || kind == 1);
         sw   = (kind == 2 || kind == 3);
         rw   = 1'($urandom);
         run_op("rand", v, lr, sw, 3'($urandom), a, wd, rd,
                $urandom_range(0, 3), rw, 2'($urandom), 5'($urandom));
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_wait_hold();
      test_reset_mid_wait();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
